// File: rtl/ecc_hamming_scrubber_if.sv
// Host-side and memory-side access buses of the scrub controller.
// master: the scrubber; slave: the host plus the ECC memory around it.
interface ecc_hamming_scrubber_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  host_wr_en;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_err;

  modport master (
    input  host_wr_en, host_addr, host_wdata, mem_rdata, mem_err,
    output host_rdata, mem_wr_en, mem_addr, mem_wdata
  );

  modport slave (
    output host_wr_en, host_addr, host_wdata, mem_rdata, mem_err,
    input  host_rdata, mem_wr_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ecc_hamming_scrubber.sv
// Background scrubber for a Hamming SEC memory: periodically reads each word and
// writes back the corrected value when the decoder flags a single-bit fix.
module ecc_hamming_scrubber #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int INTERVAL   = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_hamming_scrubber_if.master bus,
  input  logic                  scrub_en,
  output logic                  scrub_busy,
  output logic [ADDR_WIDTH-1:0] scrub_addr,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] last_err_addr,
  output logic                  pass_done
);
  localparam int IW = $clog2(INTERVAL);
  localparam logic [IW-1:0] RELOAD = IW'(INTERVAL - 1);

  typedef enum logic [1:0] {IDLE, RD, CHK, WB} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  errc_q, errc_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic                  pass_q, pass_d;
  logic                  busy_q, busy_d;
  logic                  advance;
  logic                  host_hit;

  // A host write to the word being scrubbed makes the corrected copy stale.
  assign host_hit = bus.host_wr_en && (bus.host_addr == addr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    errc_d  = errc_q;
    last_d  = last_q;
    cap_d   = cap_q;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (!scrub_en) cnt_d = RELOAD;
        else if (cnt_q == '0) begin
          cnt_d   = RELOAD;
          state_d = RD;
        end else cnt_d = cnt_q - 1'b1;
      end
      RD: if (!bus.host_wr_en) state_d = CHK;
      CHK: begin
        cap_d = bus.mem_rdata;
        if (!bus.mem_err) begin
          advance = 1'b1;
          state_d = IDLE;
        end else begin
          if (~&errc_q) errc_d = errc_q + 1'b1;
          last_d = addr_q;
          if (host_hit) begin
            advance = 1'b1;
            state_d = IDLE;
          end else state_d = WB;
        end
      end
      WB: begin
        // Only a write to some other word holds off the writeback.
        if (!bus.host_wr_en || host_hit) begin
          advance = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    addr_d = advance ? addr_q + 1'b1 : addr_q;
    pass_d = advance && (&addr_q);
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = bus.host_addr;
    bus.mem_wdata = bus.host_wdata;
    if (bus.host_wr_en) bus.mem_wr_en = 1'b1;
    else if (state_q == RD || state_q == WB) begin
      bus.mem_addr = addr_q;
      if (state_q == WB) begin
        bus.mem_wr_en = 1'b1;
        bus.mem_wdata = cap_q;
      end
    end
  end

  assign bus.host_rdata = bus.mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= RELOAD;
      addr_q  <= '0;
      errc_q  <= '0;
      last_q  <= '0;
      cap_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      errc_q  <= errc_d;
      last_q  <= last_d;
      cap_q   <= cap_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
    end
  end

  assign scrub_busy    = busy_q;
  assign scrub_addr    = addr_q;
  assign err_count     = errc_q;
  assign last_err_addr = last_q;
  assign pass_done     = pass_q;
endmodule

// File: doc/ecc_hamming_scrubber.md
Name: ecc_hamming_scrubber

Overview:
- Background scrub controller on the host side of the Hamming SEC faulty memory, which encodes on write and decodes on read.
- Multiplexes host accesses with periodic scrub reads onto the memory's single address/write port.
- Consumes the decoded data and the single-bit-corrected flag, and writes corrected data back so latent single-bit faults are repaired before a second fault makes them uncorrectable.
- Keeps error statistics for software.

Parameters:
- ADDR_WIDTH, 4, memory address width (depth = 2**ADDR_WIDTH).
- DATA_WIDTH, 8, unencoded data width.
- INTERVAL, 256, idle cycles between scrub operations (>=2).
- CNT_WIDTH, 16, width of the corrected-error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- scrub_en  in  1  enables background scrubbing.
- host_wr_en  in  1  host write strobe.
- host_addr  in  ADDR_WIDTH  host read/write address.
- host_wdata  in  DATA_WIDTH  host write data.
- host_rdata  out  DATA_WIDTH  decoded read data, passed through from mem_rdata.
- mem_wr_en  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  data to the encoder.
- mem_rdata  in  DATA_WIDTH  decoded read data from memory, valid the cycle after its address was driven.
- mem_err  in  1  single-bit-corrected flag, aligned with mem_rdata.
- scrub_busy  out  1  high in RD, CHK and WB; while high, host read data is not guaranteed.
- scrub_addr  out  ADDR_WIDTH  current scrub pointer.
- err_count  out  CNT_WIDTH  saturating count of corrected errors found by scrub.
- last_err_addr  out  ADDR_WIDTH  address of the most recent scrub-detected error.
- pass_done  out  1  one-cycle pulse when the pointer wraps from max to 0.

Behaviour:
- Reset (rst=0, async): state=IDLE; interval counter=INTERVAL-1; scrub_addr=0; err_count=0; last_err_addr=0; pass_done=0; all registered outputs 0.
- Port mux (combinational):
  - host_wr_en=1 always wins: mem_wr_en=1, mem_addr=host_addr, mem_wdata=host_wdata.
  - Else in RD or WB: mem_addr=scrub_addr. In WB, if writeback is pending, mem_wr_en=1 and mem_wdata=captured data.
  - Else: mem_addr=host_addr, mem_wr_en=0.
- IDLE:
  - While scrub_en=1, the counter decrements each cycle. At 0, go to RD and reload the counter.
  - scrub_en=0 holds the counter at INTERVAL-1.
- RD:
  - Drives scrub_addr. If host_wr_en=1 this cycle, stay in RD (stall). Otherwise go to CHK.
- CHK:
  - Sample mem_rdata/mem_err into a capture register.
  - mem_err=0: no writeback; advance the pointer; go to IDLE.
  - mem_err=1:
    - err_count += 1, saturating at all-ones.
    - last_err_addr = scrub_addr.
    - If host_wr_en=1 and host_addr==scrub_addr this cycle, the host data supersedes: skip writeback, advance, go to IDLE.
    - Otherwise go to WB.
- WB:
  - If host_wr_en=1 and host_addr==scrub_addr: drop the writeback, advance, go to IDLE.
  - If host_wr_en=1 to another address: stall in WB.
  - Otherwise write the captured data for one cycle, advance, go to IDLE.
- Advance: scrub_addr+1, wrapping max→0. The wrap asserts pass_done for exactly the following cycle.
- Latency: a scrub op is 2 cycles (clean) or 3 cycles (corrected), plus any host stall cycles.
- scrub_en deassert mid-op: the current op completes, then the block stays in IDLE.
- Async reset mid-op aborts immediately. No partial write is issued after reset.

Test Plan:
- Write 0xA5 to all 16 addresses, scrub_en=1, INTERVAL=4, no faults → 16 ops with mem_wr_en only from the host, err_count=0, pass_done pulses once after address 15.
- Fault at bit 3 on address 6 during the scrub read → CHK sees mem_err=1, WB writes 0xA5 to address 6, err_count=1, last_err_addr=6; re-read with fault disabled gives 0xA5 and mem_err=0.
- Host write 0x3C to address 6 in the WB cycle for address 6 → no scrub write issued, memory holds 0x3C, err_count still increments.
- Host writes on consecutive cycles during RD → FSM stalls in RD; scrub read issues the cycle after the host stops; scrub_busy high throughout.
- 65536+ forced errors with CNT_WIDTH=16 → err_count saturates at 0xFFFF.
- Assert rst low while in WB → all outputs 0 asynchronously, no mem_wr_en; after release the block restarts from address 0.
